// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the instruction-decode stage: opcodes, functs,
// the JAL link-register default and the instruction class enumeration.
package id_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;

  localparam logic [4:0] LINK_REG_DEFAULT = 5'd31;

  typedef enum logic [2:0] {
    CLS_RTYPE,
    CLS_IMM,
    CLS_SRC2_NODEST,
    CLS_JUMP,
    CLS_LINK,
    CLS_ILLEGAL
  } instrClass_e;

  function automatic instrClass_e classify(input logic [5:0] op);
    case (op)
      OP_RTYPE:                                   return CLS_RTYPE;
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LW:   return CLS_IMM;
      OP_BEQ, OP_BNE, OP_SW:                      return CLS_SRC2_NODEST;
      OP_J:                                       return CLS_JUMP;
      OP_JAL:                                     return CLS_LINK;
      default:                                    return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/id_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, r0 never pending.
module id_scoreboard (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_setEn,
  input  logic [4:0] i_setReg,
  input  logic       i_clrEn,
  input  logic [4:0] i_clrReg,
  input  logic [4:0] i_lookupReg1,
  input  logic [4:0] i_lookupReg2,
  output logic       o_pending1,
  output logic       o_pending2
);

  logic [31:0] r_pending;

  // A new producer claiming a register outranks a retiring older write to it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pending <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (i_setEn && (i_setReg == 5'(i)))
          r_pending[i] <= 1'b1;
        else if (i_clrEn && (i_clrReg == 5'(i)))
          r_pending[i] <= 1'b0;
      end
      r_pending[0] <= 1'b0;
    end
  end

  assign o_pending1 = r_pending[i_lookupReg1];
  assign o_pending2 = r_pending[i_lookupReg2];

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage with scoreboard interlock and one registered output slot.
// Define WB_BYPASS_EN to forward same-cycle writeback data instead of stalling.
module id_stage
  import id_stage_pkg::*;
#(
  parameter logic [4:0] LINK_REG = LINK_REG_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_instrValid,
  input  logic [31:0] i_instr,
  output logic        o_instrReady,
  output logic [4:0]  o_readRegister1,
  output logic [4:0]  o_readRegister2,
  input  logic [31:0] i_readData1,
  input  logic [31:0] i_readData2,
  input  logic        i_wbValid,
  input  logic [4:0]  i_wbRegister,
  input  logic [31:0] i_wbData,
  output logic        o_outValid,
  input  logic        i_outReady,
  output logic [5:0]  o_outOp,
  output logic [5:0]  o_outFunct,
  output logic [31:0] o_outA,
  output logic [31:0] o_outB,
  output logic [31:0] o_outImm,
  output logic [4:0]  o_outDest,
  output logic        o_outRegWrite,
  output logic        o_outIllegal
);

  logic [5:0]  w_op;
  logic [4:0]  w_rs, w_rt, w_rd;
  instrClass_e w_class;
  logic        w_readsRs, w_readsRt, w_illegal, w_regWrite;
  logic [4:0]  w_dest;
  logic        w_pend1, w_pend2, w_byp1, w_byp2, w_stall, w_accept;
  logic [31:0] w_opA, w_opB;

  logic        r_outValid, r_outRegWrite, r_outIllegal;
  logic [5:0]  r_outOp, r_outFunct;
  logic [31:0] r_outA, r_outB, r_outImm;
  logic [4:0]  r_outDest;

  assign w_op  = i_instr[31:26];
  assign w_rs  = i_instr[25:21];
  assign w_rt  = i_instr[20:16];
  assign w_rd  = i_instr[15:11];
  assign w_class = classify(w_op);

  assign o_readRegister1 = w_rs;
  assign o_readRegister2 = w_rt;

  always_comb begin
    w_readsRs = 1'b0;
    w_readsRt = 1'b0;
    w_illegal = 1'b0;
    w_dest    = 5'd0;
    case (w_class)
      CLS_RTYPE:       begin w_readsRs = 1'b1; w_readsRt = 1'b1; w_dest = w_rd; end
      CLS_IMM:         begin w_readsRs = 1'b1; w_dest = w_rt; end
      CLS_SRC2_NODEST: begin w_readsRs = 1'b1; w_readsRt = 1'b1; end
      CLS_JUMP:        ;
      CLS_LINK:        w_dest = LINK_REG;
      default:         w_illegal = 1'b1;
    endcase
  end

  assign w_regWrite = (w_dest != 5'd0);

  id_scoreboard u_scoreboard (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_setEn      (w_accept && w_regWrite),
    .i_setReg     (w_dest),
    .i_clrEn      (i_wbValid),
    .i_clrReg     (i_wbRegister),
    .i_lookupReg1 (w_rs),
    .i_lookupReg2 (w_rt),
    .o_pending1   (w_pend1),
    .o_pending2   (w_pend2)
  );

`ifdef WB_BYPASS_EN
  assign w_byp1 = i_wbValid && (i_wbRegister != 5'd0) && (i_wbRegister == w_rs);
  assign w_byp2 = i_wbValid && (i_wbRegister != 5'd0) && (i_wbRegister == w_rt);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  assign w_stall = i_instrValid && ((w_readsRs && w_pend1 && !w_byp1) ||
                                    (w_readsRt && w_pend2 && !w_byp2));
  assign o_instrReady = !w_stall && (!r_outValid || i_outReady) && !i_reset;
  assign w_accept     = i_instrValid && o_instrReady;

  assign w_opA = (w_readsRs && w_pend1 && w_byp1) ? i_wbData : i_readData1;
  assign w_opB = (w_readsRt && w_pend2 && w_byp2) ? i_wbData : i_readData2;

  // Output slot: loads on accept, otherwise holds until the consumer takes it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_outValid    <= 1'b0;
      r_outOp       <= '0;
      r_outFunct    <= '0;
      r_outA        <= '0;
      r_outB        <= '0;
      r_outImm      <= '0;
      r_outDest     <= '0;
      r_outRegWrite <= 1'b0;
      r_outIllegal  <= 1'b0;
    end else if (w_accept) begin
      r_outValid    <= 1'b1;
      r_outOp       <= w_op;
      r_outFunct    <= i_instr[5:0];
      r_outA        <= w_opA;
      r_outB        <= w_opB;
      r_outImm      <= {{16{i_instr[15]}}, i_instr[15:0]};
      r_outDest     <= w_dest;
      r_outRegWrite <= w_regWrite;
      r_outIllegal  <= w_illegal;
    end else if (r_outValid && i_outReady) begin
      r_outValid    <= 1'b0;
    end
  end

  assign o_outValid    = r_outValid;
  assign o_outOp       = r_outOp;
  assign o_outFunct    = r_outFunct;
  assign o_outA        = r_outA;
  assign o_outB        = r_outB;
  assign o_outImm      = r_outImm;
  assign o_outDest     = r_outDest;
  assign o_outRegWrite = r_outRegWrite;
  assign o_outIllegal  = r_outIllegal;

endmodule
